// File: rtl/uart_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_rx_buffer_pkg
// Brief    : Shared constants and capture-FSM encoding for the UART RX buffer.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_buffer_pkg;

    localparam int C_DATA_WIDTH = 8;
    localparam int C_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        sIdle = 2'b00,
        sAck  = 2'b01,
        sWait = 2'b10
    } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_buffer_if
// Brief     : Receiver handshake and consumer pop bus of the UART RX buffer.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_rx_buffer_if
    import uart_rx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
);
    // Directions in signal names are as seen from the buffer.
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_ready;
    logic                  o_rx_clear;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_pop;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_full;
    logic                  o_overflow;
    logic                  i_clear_overflow;

    modport master (
        input  i_rx_data, i_rx_ready, i_pop, i_clear_overflow,
        output o_rx_clear, o_data, o_valid, o_count, o_full, o_overflow
    );

    modport slave (
        output i_rx_data, i_rx_ready, i_pop, i_clear_overflow,
        input  o_rx_clear, o_data, o_valid, o_count, o_full, o_overflow
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through synchronous FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_accept,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;

    logic w_rd_accept;
    logic w_wr_accept;

    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign w_rd_accept = i_rd_en && (count_q != '0);
    assign w_wr_accept = i_wr_en && ((count_q != C_DEPTH_CNT) || w_rd_accept);

    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_rd_accept) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_wr_accept = w_wr_accept;
    assign o_rd_data   = mem_q[rd_ptr_q];
    assign o_valid     = (count_q != '0);
    assign o_count     = count_q;
    assign o_full      = (count_q == C_DEPTH_CNT);

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buffer
// Brief    : Captures UART receiver bytes into a FIFO with sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    uart_rx_buffer_if.master  bus
);

    cap_state_e state_q;
    logic       rx_clear_q;
    logic       overflow_q;

    logic                  w_wr_req;
    logic                  w_wr_accept;
    logic                  w_overflow_set;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_fifo_valid;
    logic [ADDR_WIDTH:0]   w_fifo_count;
    logic                  w_fifo_full;

    assign w_wr_req       = (state_q == sIdle) && bus.i_rx_ready;
    assign w_overflow_set = w_wr_req && !w_wr_accept;

    // The clear strobe is registered alongside the state, so it is high exactly in sAck.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= sIdle;
            rx_clear_q <= 1'b0;
        end else begin
            rx_clear_q <= 1'b0;
            case (state_q)
                sIdle: begin
                    if (bus.i_rx_ready) begin
                        state_q    <= sAck;
                        rx_clear_q <= 1'b1;
                    end
                end
                sAck: begin
                    state_q <= sWait;
                end
                sWait: begin
                    if (!bus.i_rx_ready) begin
                        state_q <= sIdle;
                    end
                end
                default: begin
                    state_q <= sIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_q <= 1'b0;
        end else if (w_overflow_set) begin
            overflow_q <= 1'b1;
        end else if (bus.i_clear_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_en     (w_wr_req),
        .i_wr_data   (bus.i_rx_data),
        .o_wr_accept (w_wr_accept),
        .i_rd_en     (bus.i_pop),
        .o_rd_data   (w_fifo_data),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full)
    );

    assign bus.o_rx_clear = rx_clear_q;
    assign bus.o_data     = w_fifo_data;
    assign bus.o_valid    = w_fifo_valid;
    assign bus.o_count    = w_fifo_count;
    assign bus.o_full     = w_fifo_full;
    assign bus.o_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buffer
// Brief    : Self-checking bench for uart_rx_buffer with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;
    import uart_rx_buffer_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_rx_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: byte queue, sticky flag, and the receiver handshake rule
    // (one capture per ready assertion; ready must be seen low after the ack).
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_clear;
    bit         m_armed;
    bit         m_blind;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       pop;
        logic       clr;
        logic       e_clear;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_count;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [8];

    logic cap_clear;
    logic [4:0] cap_count;
    logic cap_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_clear = 1'b0;
        m_armed = 1'b1;
        m_blind = 1'b0;
    endfunction

    function automatic void model_edge();
        bit cap;
        bit dropped;
        if (rst) begin
            model_reset();
            return;
        end
        cap     = m_armed && bus.i_rx_ready;
        dropped = 1'b0;
        if (bus.i_pop && mq.size() != 0) begin
            void'(mq.pop_front());
        end
        if (cap) begin
            if (mq.size() < DEPTH) mq.push_back(bus.i_rx_data);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (bus.i_clear_overflow) m_ovf = 1'b0;
        if (cap) begin
            m_armed = 1'b0;
            m_blind = 1'b1;
        end else if (!m_armed) begin
            if (m_blind) m_blind = 1'b0;
            else if (!bus.i_rx_ready) m_armed = 1'b1;
        end
        m_clear = cap;
    endfunction

    task automatic check_model();
        chk("clear", 32'(bus.o_rx_clear), 32'(m_clear));
        chk("valid", 32'(bus.o_valid), 32'(mq.size() != 0));
        chk("count", 32'(bus.o_count), mq.size());
        chk("full", 32'(bus.o_full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("data", 32'(bus.o_data), 32'(mq[0]));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic deliver(input logic [7:0] b, input logic pop_on_cap);
        bus.i_rx_ready = 1'b1;
        bus.i_rx_data  = b;
        bus.i_pop      = pop_on_cap;
        tick();
        cap_clear = bus.o_rx_clear;
        cap_count = bus.o_count;
        cap_ovf   = bus.o_overflow;
        bus.i_pop = 1'b0;
        tick();
        bus.i_rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.i_pop = 1'b1;
        tick();
        bus.i_pop = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && bus.o_valid; k++) pop_one();
        chk("drained", 32'(bus.o_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int clears;
        int hold_left;
        int gap;
        int pct;
        logic [4:0] cnt_before;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0};
        tbl[5] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

        rst                  = 1'b1;
        bus.i_rx_data        = '0;
        bus.i_rx_ready       = 1'b0;
        bus.i_pop            = 1'b0;
        bus.i_clear_overflow = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // Single byte and empty-pop cases from the vector table.
        for (int i = 0; i < 8; i++) begin
            bus.i_rx_ready       = tbl[i].rdy;
            bus.i_rx_data        = tbl[i].d;
            bus.i_pop            = tbl[i].pop;
            bus.i_clear_overflow = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_clear", i), 32'(bus.o_rx_clear), 32'(tbl[i].e_clear));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_count", i), 32'(bus.o_count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_ovf", i), 32'(bus.o_overflow), 32'(tbl[i].e_ovf));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), 32'(bus.o_data), 32'(tbl[i].e_data));
        end
        bus.i_clear_overflow = 1'b0;

        // Fill and wrap.
        for (int b = 0; b < 16; b++) deliver(8'(b), 1'b0);
        chk("fill_full", 32'(bus.o_full), 32'd1);
        chk("fill_count", 32'(bus.o_count), 32'd16);
        for (int k = 0; k < 4; k++) pop_one();
        for (int b = 16; b < 20; b++) deliver(8'(b), 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk("wrap_order", 32'(bus.o_data), 32'(4 + k));
            pop_one();
        end
        chk("wrap_ovf", 32'(bus.o_overflow), 32'd0);

        // Overflow when full, then clear.
        for (int b = 0; b < 16; b++) deliver(8'(8'h20 + b), 1'b0);
        deliver(8'h77, 1'b0);
        chk("ovf_clear_pulse", 32'(cap_clear), 32'd1);
        chk("ovf_count", 32'(cap_count), 32'd16);
        chk("ovf_set", 32'(cap_ovf), 32'd1);
        bus.i_clear_overflow = 1'b1;
        tick();
        bus.i_clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(bus.o_overflow), 32'd0);

        // Full with simultaneous pop.
        deliver(8'h88, 1'b1);
        chk("fullpop_count", 32'(cap_count), 32'd16);
        chk("fullpop_ovf", 32'(cap_ovf), 32'd0);
        for (int k = 0; k < 15; k++) pop_one();
        chk("fullpop_last", 32'(bus.o_data), 32'h88);
        pop_one();
        chk("fullpop_empty", 32'(bus.o_valid), 32'd0);

        // Stuck ready.
        cnt_before     = bus.o_count;
        clears         = 0;
        bus.i_rx_ready = 1'b1;
        bus.i_rx_data  = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            tick();
            clears += int'(bus.o_rx_clear);
        end
        chk("stuck_clears", clears, 32'd1);
        chk("stuck_count", 32'(bus.o_count), 32'(cnt_before) + 32'd1);
        bus.i_rx_ready = 1'b0;
        tick();
        drain();

        // Reset in the ack cycle with three bytes queued.
        for (int b = 0; b < 3; b++) deliver(8'(8'h31 + b), 1'b0);
        bus.i_rx_ready = 1'b1;
        bus.i_rx_data  = 8'h99;
        tick();
        chk("rst_pre_clear", 32'(bus.o_rx_clear), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_clear", 32'(bus.o_rx_clear), 32'd0);
        chk("rst_async_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_async_count", 32'(bus.o_count), 32'd0);
        chk("rst_async_full", 32'(bus.o_full), 32'd0);
        chk("rst_async_ovf", 32'(bus.o_overflow), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_recapture_data", 32'(bus.o_data), 32'h99);
        chk("rst_recapture_clear", 32'(bus.o_rx_clear), 32'd1);
        tick();
        bus.i_rx_ready = 1'b0;
        tick();
        drain();

        // Randomized traffic at three pop rates.
        hold_left = -1;
        gap       = 0;
        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
            for (int cyc = 0; cyc < 800; cyc++) begin
                bus.i_pop            = ($urandom_range(0, 99) < pct);
                bus.i_clear_overflow = ($urandom_range(0, 31) == 0);
                if (bus.i_rx_ready) begin
                    if (hold_left == 0) begin
                        bus.i_rx_ready = 1'b0;
                        hold_left      = -1;
                        gap            = $urandom_range(0, 3);
                    end else if (hold_left > 0) begin
                        hold_left--;
                    end
                end else if (gap > 0) begin
                    gap--;
                end else if ($urandom_range(0, 1) == 1) begin
                    bus.i_rx_ready = 1'b1;
                    bus.i_rx_data  = 8'($urandom);
                end
                tick();
                if (bus.i_rx_ready && bus.o_rx_clear)
                    hold_left = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
